// File: rtl/cpu_fetch.sv
// Instruction fetch engine for mox125: single-outstanding Wishbone classic
// read master that feeds big-endian 32-bit fetch words into the instruction
// FIFO, repacking halfwords when the fetch target is halfword aligned.
module cpu_fetch #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_i,
  input  logic [31:0] branch_pc_i,
  input  logic        fifo_full_i,
  output logic        fifo_we_o,
  output logic [31:0] data_o,
  output logic [31:0] pc_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned HALF = 16;
  localparam int unsigned SELW = 4;

  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] HALF_MASK = ~XLEN'(1);
  localparam logic [XLEN-1:0] STEP      = XLEN'(4);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic [XLEN-1:0]   adr_q, adr_d;
  logic [XLEN-1:0]   fetch_adr_q, fetch_adr_d;
  logic              misalign_q, misalign_d;
  logic [HALF-1:0]   hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic [XLEN-1:0]   out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              push_c;

  // A word leaves toward the FIFO whenever one is held, the FIFO has room and
  // no redirect is invalidating it in the same cycle.
  assign push_c = out_valid_q & ~fifo_full_i & ~branch_i;

  assign fifo_we_o = push_c;
  assign data_o    = out_q;
  assign pc_o      = pc_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_adr_o  = adr_q;
  assign wb_sel_o  = {SELW{1'b1}};

  // Next-state, bus request, repacking and redirect logic.
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    adr_d        = adr_q;
    fetch_adr_d  = fetch_adr_q;
    misalign_d   = misalign_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    pc_d         = pc_q;

    if (push_c) begin
      out_valid_d = 1'b0;
      pc_d        = pc_q + STEP;
    end

    unique case (state_q)
      ST_REQ: begin
        if (!branch_i && !out_valid_q) begin
          cyc_d   = 1'b1;
          adr_d   = fetch_adr_q;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wb_ack_i) begin
          cyc_d       = 1'b0;
          state_d     = ST_REQ;
          fetch_adr_d = fetch_adr_q + STEP;
          if (!branch_i) begin
            if (!misalign_q) begin
              out_d       = wb_dat_i;
              out_valid_d = 1'b1;
            end else begin
              // Low half of this word is the first half of the next fetch word.
              hold_d       = wb_dat_i[HALF-1:0];
              hold_valid_d = 1'b1;
              if (hold_valid_q) begin
                out_d       = {hold_q, wb_dat_i[XLEN-1:HALF]};
                out_valid_d = 1'b1;
              end
            end
          end
        end else if (branch_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The stale cycle must complete; its data is thrown away.
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          state_d = ST_REQ;
        end
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = ST_REQ;
      end
    endcase

    // Redirect wins over everything except an in-flight bus cycle.
    if (branch_i) begin
      fetch_adr_d  = branch_pc_i & WORD_MASK;
      misalign_d   = branch_pc_i[1];
      pc_d         = branch_pc_i & HALF_MASK;
      out_valid_d  = 1'b0;
      hold_valid_d = 1'b0;
    end
  end

  // State and datapath registers; reset also drops any bus cycle at once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_REQ;
      cyc_q        <= 1'b0;
      adr_q        <= BOOT_ADDRESS & WORD_MASK;
      fetch_adr_q  <= BOOT_ADDRESS & WORD_MASK;
      misalign_q   <= BOOT_ADDRESS[1];
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      pc_q         <= BOOT_ADDRESS & HALF_MASK;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      adr_q        <= adr_d;
      fetch_adr_q  <= fetch_adr_d;
      misalign_q   <= misalign_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      pc_q         <= pc_d;
    end
  end

endmodule

// File: tb/tb_cpu_fetch.sv
// Testbench for cpu_fetch: Wishbone memory with configurable ack latency,
// push/bus monitors, and a halfword-addressed memory reference model.
module tb_cpu_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_pc_i = 32'h0;
  logic        fifo_full_i = 1'b0;
  logic        fifo_we_o;
  logic [31:0] data_o;
  logic [31:0] pc_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack;
  logic [31:0] wb_dat;

  cpu_fetch #(.BOOT_ADDRESS(32'h0000_1000)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .branch_i    (branch_i),
    .branch_pc_i (branch_pc_i),
    .fifo_full_i (fifo_full_i),
    .fifo_we_o   (fifo_we_o),
    .data_o      (data_o),
    .pc_o        (pc_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_adr_o    (wb_adr_o),
    .wb_sel_o    (wb_sel_o),
    .wb_ack_i    (wb_ack),
    .wb_dat_i    (wb_dat)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  // Memory contents: explicit words where a test needs them, a hash elsewhere.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (mem.exists(w)) return mem[w];
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_rd(a);
    return a[1] ? w[15:0] : w[31:16];
  endfunction

  // Reference: the fetch word at halfword address p is two consecutive halfwords.
  function automatic logic [31:0] exp_word(input logic [31:0] p);
    return {half_at(p), half_at(p + 32'd2)};
  endfunction

  // Wishbone slave with fixed or random ack latency.
  int fixed_delay = 0;
  bit rand_delay = 1'b0;
  initial begin : slave
    int cnt;
    int cur;
    bit busy;
    wb_ack = 1'b0;
    wb_dat = 32'h0;
    busy = 1'b0;
    cnt = 0;
    cur = 0;
    forever begin
      @(negedge clk_i);
      if (wb_cyc_o && wb_stb_o && !wb_ack) begin
        if (!busy) begin
          busy = 1'b1;
          cnt = 0;
          cur = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
        end
        if (cnt >= cur) begin
          wb_ack = 1'b1;
          wb_dat = mem_rd(wb_adr_o);
          busy = 1'b0;
        end else begin
          cnt++;
        end
      end else begin
        wb_ack = 1'b0;
        wb_dat = $urandom;
        busy = 1'b0;
      end
    end
  end

  int cycle = 0;
  initial forever begin
    @(posedge clk_i);
    cycle++;
  end

  // Monitor: every FIFO push and every bus cycle start, in order.
  logic [31:0] push_data [$];
  logic [31:0] push_pc [$];
  int          push_t [$];
  logic [31:0] start_adr [$];
  initial begin : monitor
    bit cyc_prev;
    cyc_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (fifo_we_o) begin
        push_data.push_back(data_o);
        push_pc.push_back(pc_o);
        push_t.push_back(cycle);
      end
      if (wb_cyc_o && !cyc_prev) start_adr.push_back(wb_adr_o);
      cyc_prev = wb_cyc_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  logic [31:0] exp_pc = 32'h0;
  int rd_push = 0;
  int branch_sidx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Compare all not-yet-checked pushes against the sequential-fetch model.
  task automatic check_pushes();
    while (rd_push < push_data.size()) begin
      chk("push_pc", push_pc[rd_push], exp_pc);
      chk("push_data", push_data[rd_push], exp_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      rd_push++;
    end
  endtask

  task automatic wait_start(input int n);
    int k;
    k = 0;
    while (start_adr.size() < branch_sidx + n && k < 200) begin
      step_cycle();
      k++;
    end
    chk1("wait_bus_start", start_adr.size() >= branch_sidx + n, 1'b1);
  endtask

  task automatic wait_push(input int n);
    int k;
    k = 0;
    while (push_data.size() < rd_push + n && k < 200) begin
      step_cycle();
      k++;
    end
    chk1("wait_push", push_data.size() >= rd_push + n, 1'b1);
  endtask

  // One-cycle redirect pulse; returns at the start of the following cycle.
  task automatic do_branch(input logic [31:0] tgt);
    check_pushes();
    branch_i = 1'b1;
    branch_pc_i = tgt;
    @(negedge clk_i);
    chk1("branch_we", fifo_we_o, 1'b0);
    branch_sidx = start_adr.size();
    exp_pc = tgt & 32'hFFFF_FFFE;
    step_cycle();
    branch_i = 1'b0;
    branch_pc_i = $urandom;
  endtask

  initial begin
    bit found;
    logic [31:0] tgt;
    int n0;

    mem[32'h0000_1000] = 32'h0100_1234;
    mem[32'h0000_1004] = 32'h5678_ABCD;
    mem[32'h0000_2000] = 32'hAAAA_1111;
    mem[32'h0000_2004] = 32'h2222_BBBB;

    // Reset values
    repeat (2) step_cycle();
    @(negedge clk_i);
    chk1("rst_we", fifo_we_o, 1'b0);
    chk("rst_data", data_o, 32'h0);
    chk1("rst_cyc", wb_cyc_o, 1'b0);
    chk1("rst_stb", wb_stb_o, 1'b0);
    chk("rst_sel", 32'(wb_sel_o), 32'hF);
    chk("rst_adr", wb_adr_o, 32'h1000);
    chk("rst_pc", pc_o, 32'h1000);
    step_cycle();
    rst_i = 1'b1;
    exp_pc = 32'h1000;

    // Boot fetch, aligned, zero-wait throughput
    wait_start(1);
    chk("boot_adr", start_adr[0], 32'h1000);
    wait_push(2);
    chk("boot_w0", push_data[rd_push], 32'h0100_1234);
    chk("boot_pc0", push_pc[rd_push], 32'h1000);
    chk("boot_w1", push_data[rd_push + 1], 32'h5678_ABCD);
    chk("boot_pc1", push_pc[rd_push + 1], 32'h1004);
    chk("boot_gap", 32'(push_t[rd_push + 1] - push_t[rd_push]), 32'd3);
    check_pushes();

    // Misaligned redirect
    do_branch(32'h0000_2002);
    wait_start(2);
    chk("mis_adr0", start_adr[branch_sidx], 32'h2000);
    chk("mis_adr1", start_adr[branch_sidx + 1], 32'h2004);
    wait_push(1);
    chk("mis_w0", push_data[rd_push], 32'h1111_2222);
    chk("mis_pc0", push_pc[rd_push], 32'h2002);
    check_pushes();

    // FIFO back-pressure
    fifo_full_i = 1'b1;
    do_branch(32'h0000_4000);
    repeat (6) step_cycle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk1("full_we", fifo_we_o, 1'b0);
      chk1("full_cyc", wb_cyc_o, 1'b0);
      chk("full_data", data_o, exp_word(32'h4000));
      chk("full_pc", pc_o, 32'h4000);
      step_cycle();
    end
    fifo_full_i = 1'b0;
    @(negedge clk_i);
    chk1("release_we", fifo_we_o, 1'b1);
    step_cycle();
    @(negedge clk_i);
    chk1("release_we_once", fifo_we_o, 1'b0);
    step_cycle();
    wait_start(2);
    chk("resume_adr", start_adr[branch_sidx + 1], 32'h4004);
    check_pushes();

    // Redirect while a slow cycle is in flight: drain at old address
    fixed_delay = 4;
    do_branch(32'h0000_1004);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk_i);
      if (wb_cyc_o && wb_adr_o == 32'h1004) found = 1'b1;
      else step_cycle();
    end
    chk1("drain_found", found, 1'b1);
    step_cycle();
    do_branch(32'h0000_3000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk1("drain_cyc", wb_cyc_o, 1'b1);
      chk1("drain_stb", wb_stb_o, 1'b1);
      chk("drain_adr", wb_adr_o, 32'h1004);
      chk1("drain_we", fifo_we_o, 1'b0);
      step_cycle();
    end
    wait_start(1);
    chk("drain_next_adr", start_adr[branch_sidx], 32'h3000);
    wait_push(1);
    chk("drain_first_pc", push_pc[rd_push], 32'h3000);
    check_pushes();
    fixed_delay = 0;

    // Redirect coincident with ack
    do_branch(32'h0000_5000);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (wb_cyc_o && wb_adr_o == 32'h5000) found = 1'b1;
      else step_cycle();
    end
    chk1("coin_found", found, 1'b1);
    do_branch(32'h0000_6000);
    chk1("coin_ack", wb_ack, 1'b1);
    chk1("coin_cyc_drop", wb_cyc_o, 1'b0);
    wait_start(1);
    chk("coin_next_adr", start_adr[branch_sidx], 32'h6000);
    wait_push(1);
    chk("coin_first_pc", push_pc[rd_push], 32'h6000);
    check_pushes();

    // Asynchronous reset in the middle of a bus cycle
    fixed_delay = 3;
    do_branch(32'h0000_7000);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (wb_cyc_o && wb_adr_o == 32'h7000) found = 1'b1;
      else step_cycle();
    end
    chk1("arst_found", found, 1'b1);
    check_pushes();
    rst_i = 1'b0;
    #1;
    chk1("arst_cyc", wb_cyc_o, 1'b0);
    chk1("arst_stb", wb_stb_o, 1'b0);
    chk1("arst_we", fifo_we_o, 1'b0);
    chk("arst_adr", wb_adr_o, 32'h1000);
    chk("arst_pc", pc_o, 32'h1000);
    chk("arst_data", data_o, 32'h0);
    step_cycle();
    step_cycle();
    rst_i = 1'b1;
    exp_pc = 32'h1000;
    branch_sidx = start_adr.size();
    fixed_delay = 0;
    wait_start(1);
    chk("rerun_adr", start_adr[branch_sidx], 32'h1000);
    wait_push(1);
    chk("rerun_w0", push_data[rd_push], 32'h0100_1234);
    check_pushes();

    // Address wrap, aligned and misaligned (bit 0 set must be ignored)
    do_branch(32'hFFFF_FFFC);
    wait_start(2);
    chk("wrap_adr0", start_adr[branch_sidx], 32'hFFFF_FFFC);
    chk("wrap_adr1", start_adr[branch_sidx + 1], 32'h0000_0000);
    wait_push(2);
    check_pushes();
    do_branch(32'hFFFF_FFFF);
    wait_start(2);
    chk("wrapm_adr0", start_adr[branch_sidx], 32'hFFFF_FFFC);
    chk("wrapm_adr1", start_adr[branch_sidx + 1], 32'h0000_0000);
    wait_push(1);
    chk("wrapm_pc0", push_pc[rd_push], 32'hFFFF_FFFE);
    check_pushes();

    // Randomized: latency, back-pressure and redirects
    rand_delay = 1'b1;
    n0 = push_data.size();
    for (int i = 0; i < 500; i++) begin
      fifo_full_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) begin
        tgt = $urandom;
        if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
        else tgt = tgt & 32'h0000_3FFF;
        do_branch(tgt);
      end else begin
        @(negedge clk_i);
        chk("rand_sel", 32'(wb_sel_o), 32'hF);
        chk("rand_adr_lsb", 32'(wb_adr_o[1:0]), 32'h0);
        step_cycle();
      end
    end
    fifo_full_i = 1'b0;
    rand_delay = 1'b0;
    repeat (30) step_cycle();
    check_pushes();
    chk1("rand_activity", (push_data.size() - n0) > 20, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
